// File: rtl/fir_push_tx_pkg.sv
// Shared constants and types for the FIR push/stop transmitter.
// The load-timeout feature is enabled by defining FIR_PUSH_TX_LOAD_TIMEOUT_EN.
package fir_push_tx_pkg;

    localparam int DWIDTH_DEF    = 24;
    localparam int CWIDTH_DEF    = 27;
    localparam int NTAPS_DEF     = 29;
    localparam int AWIDTH_DEF    = 5;
    localparam int DEPTH_DEF     = 4;

    localparam int TMO_W         = 8;
    localparam int TIMEOUT_LIMIT = 255;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    // Next coefficient address, wrapping after the last tap.
    function automatic logic [AWIDTH_DEF-1:0] next_addr(
        input logic [AWIDTH_DEF-1:0] addr,
        input logic [AWIDTH_DEF-1:0] last
    );
        return (addr == last) ? '0 : addr + 1'b1;
    endfunction

endpackage

// File: rtl/fir_pair_fifo.sv
// DEPTH-deep two-lane (I/Q) FIFO with registered full/empty and a
// combinational head read; pointers and flags reset asynchronously.
module fir_pair_fifo
    import fir_push_tx_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int WIDTH = DWIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic signed [WIDTH-1:0] wr_i,
    input  logic signed [WIDTH-1:0] wr_q,
    input  logic                    rd_en,
    output logic signed [WIDTH-1:0] head_i,
    output logic signed [WIDTH-1:0] head_q,
    output logic                    full,
    output logic                    empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic signed [WIDTH-1:0] mem_i [DEPTH];
    logic signed [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [CW-1:0]           count;
    logic [CW-1:0]           count_next;

    always_comb begin
        count_next = count;
        case ({wr_en, rd_en})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_i[wr_ptr] <= wr_i;
            mem_q[wr_ptr] <= wr_q;
        end
    end

    assign head_i = mem_i[rd_ptr];
    assign head_q = mem_q[rd_ptr];

endmodule

// File: rtl/fir_push_tx.sv
// Push/stop transmitter feeding samples and coefficient loads into the FIR.
// Optional load timeout enabled by defining FIR_PUSH_TX_LOAD_TIMEOUT_EN.
module fir_push_tx
    import fir_push_tx_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int CWIDTH = CWIDTH_DEF,
    parameter int NTAPS  = NTAPS_DEF,
    parameter int AWIDTH = AWIDTH_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [DWIDTH-1:0] s_i,
    input  logic signed [DWIDTH-1:0] s_q,
    input  logic                     c_start,
    input  logic                     c_valid,
    output logic                     c_ready,
    input  logic signed [CWIDTH-1:0] c_i,
    input  logic signed [CWIDTH-1:0] c_q,
    output logic                     load_busy,
    output logic                     load_err,
    output logic                     push_in,
    input  logic                     stop_in,
    output logic signed [DWIDTH-1:0] samp_i,
    output logic signed [DWIDTH-1:0] samp_q,
    output logic                     push_coef,
    output logic [AWIDTH-1:0]        coef_addr,
    output logic signed [CWIDTH-1:0] coef_i,
    output logic signed [CWIDTH-1:0] coef_q
);

    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(NTAPS - 1);

    state_t                  state;
    state_t                  next_state;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_wr;
    logic                    pop;
    logic                    hs;
    logic                    tmo_hit;
    logic [AWIDTH-1:0]       cnt;
    logic signed [DWIDTH-1:0] head_i;
    logic signed [DWIDTH-1:0] head_q;

    fir_pair_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DWIDTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (fifo_wr),
        .wr_i   (s_i),
        .wr_q   (s_q),
        .rd_en  (pop),
        .head_i (head_i),
        .head_q (head_q),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign fifo_wr = s_valid & s_ready;
    // The FIFO is always empty in LOAD, so samples keep flowing in RUN and DRAIN.
    assign pop     = (state != ST_LOAD) & ~fifo_empty & ~stop_in;
    assign hs      = c_valid & c_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_RUN;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_RUN:   if (c_start) next_state = ST_DRAIN;
            // Wait for the last sample push to leave before touching coefficients.
            ST_DRAIN: if (fifo_empty && !push_in) next_state = ST_LOAD;
            ST_LOAD:  if ((hs && cnt == LAST_ADDR) || tmo_hit) next_state = ST_RUN;
            default:  next_state = ST_RUN;
        endcase
    end

    always_comb begin
        s_ready = (state == ST_RUN) & ~fifo_full;
        c_ready = (state == ST_LOAD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            push_in   <= 1'b0;
            samp_i    <= '0;
            samp_q    <= '0;
            push_coef <= 1'b0;
            coef_addr <= '0;
            coef_i    <= '0;
            coef_q    <= '0;
            cnt       <= '0;
            load_busy <= 1'b0;
        end else begin
            push_in <= pop;
            if (pop) begin
                samp_i <= head_i;
                samp_q <= head_q;
            end
            push_coef <= hs;
            if (hs) begin
                coef_addr <= cnt;
                coef_i    <= c_i;
                coef_q    <= c_q;
                cnt       <= (cnt == LAST_ADDR) ? '0 : cnt + 1'b1;
            end else if (tmo_hit) begin
                cnt <= '0;
            end
            load_busy <= (next_state != ST_RUN);
        end
    end

`ifdef FIR_PUSH_TX_LOAD_TIMEOUT_EN
    logic [TMO_W-1:0] tmo;

    assign tmo_hit = (state == ST_LOAD) & ~hs & (tmo == TMO_W'(TIMEOUT_LIMIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo      <= '0;
            load_err <= 1'b0;
        end else begin
            load_err <= tmo_hit;
            if (state != ST_LOAD || hs || tmo_hit) tmo <= '0;
            else                                   tmo <= tmo + 1'b1;
        end
    end
`else
    assign tmo_hit  = 1'b0;
    assign load_err = 1'b0;
`endif

endmodule

// File: tb/tb_fir_push_tx.sv
// Self-checking bench for fir_push_tx: table-driven push sequences plus
// scoreboarded sample and coefficient streams.
module tb_fir_push_tx;

    localparam int DW = 24;
    localparam int CW = 27;
    localparam int NT = 29;
    localparam int AW = 5;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 s_valid;
    logic                 s_ready;
    logic signed [DW-1:0] s_i;
    logic signed [DW-1:0] s_q;
    logic                 c_start;
    logic                 c_valid;
    logic                 c_ready;
    logic signed [CW-1:0] c_i;
    logic signed [CW-1:0] c_q;
    logic                 load_busy;
    logic                 load_err;
    logic                 push_in;
    logic                 stop_in;
    logic signed [DW-1:0] samp_i;
    logic signed [DW-1:0] samp_q;
    logic                 push_coef;
    logic [AW-1:0]        coef_addr;
    logic signed [CW-1:0] coef_i;
    logic signed [CW-1:0] coef_q;

    fir_push_tx dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_i       (s_i),
        .s_q       (s_q),
        .c_start   (c_start),
        .c_valid   (c_valid),
        .c_ready   (c_ready),
        .c_i       (c_i),
        .c_q       (c_q),
        .load_busy (load_busy),
        .load_err  (load_err),
        .push_in   (push_in),
        .stop_in   (stop_in),
        .samp_i    (samp_i),
        .samp_q    (samp_q),
        .push_coef (push_coef),
        .coef_addr (coef_addr),
        .coef_i    (coef_i),
        .coef_q    (coef_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                 vld;
        logic signed [DW-1:0] i;
        logic signed [DW-1:0] q;
        logic                 stop;
        logic                 exp_push;
    } vec_t;

    typedef struct {
        logic signed [DW-1:0] i;
        logic signed [DW-1:0] q;
    } samp_t;

    typedef struct {
        logic [AW-1:0]        addr;
        logic signed [CW-1:0] i;
        logic signed [CW-1:0] q;
    } coef_t;

    int            checks = 0;
    int            errors = 0;
    vec_t          tbl[$];
    samp_t         sq[$];
    coef_t         cq[$];
    logic [AW-1:0] exp_addr = '0;
    logic          prev_stop = 1'b0;
    int            push_cnt = 0;
    int            acc_cnt = 0;
    int            coef_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Runs at the falling edge: records handshakes and scores filter-side pushes.
    task automatic monitor();
        samp_t s;
        coef_t c;
        if (rst) begin
            sq.delete();
            cq.delete();
            exp_addr  = '0;
            prev_stop = stop_in;
            return;
        end
        if (push_in) begin
            push_cnt++;
            check("push_after_stop", 64'(prev_stop), 64'(0));
            if (sq.size() == 0) begin
                check("samp_unexpected", 64'(1), 64'(0));
            end else begin
                s = sq.pop_front();
                check("samp_i", 64'(samp_i), 64'(s.i));
                check("samp_q", 64'(samp_q), 64'(s.q));
            end
        end
        if (s_valid && s_ready) begin
            sq.push_back('{s_i, s_q});
            acc_cnt++;
        end
        if (push_coef) begin
            coef_cnt++;
            if (cq.size() == 0) begin
                check("coef_unexpected", 64'(1), 64'(0));
            end else begin
                c = cq.pop_front();
                check("coef_addr", 64'(coef_addr), 64'(c.addr));
                check("coef_i", 64'(coef_i), 64'(c.i));
                check("coef_q", 64'(coef_q), 64'(c.q));
            end
        end
        if (load_err) exp_addr = '0;
        if (c_valid && c_ready) begin
            cq.push_back('{exp_addr, c_i, c_q});
            exp_addr = (exp_addr == AW'(NT - 1)) ? '0 : exp_addr + 1'b1;
        end
        prev_stop = stop_in;
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic run_rows(input int lo, input int hi, input string name);
        for (int k = lo; k <= hi; k++) begin
            s_valid = tbl[k].vld;
            s_i     = tbl[k].i;
            s_q     = tbl[k].q;
            stop_in = tbl[k].stop;
            step();
            check(name, 64'(push_in), 64'(tbl[k].exp_push));
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_c_ready();
        for (int k = 0; k < 60 && !c_ready; k++) step();
        check("c_ready_wait", 64'(c_ready), 64'(1));
    endtask

    task automatic start_load();
        c_start = 1'b1;
        step();
        c_start = 1'b0;
    endtask

    task automatic load_coefs(input int n);
        for (int k = 0; k < n; k++) begin
            c_valid = 1'b1;
            c_i     = CW'(k);
            c_q     = -CW'(k);
            step();
        end
        c_valid = 1'b0;
    endtask

    task automatic full_load(input string name);
        int base;
        base = coef_cnt;
        load_coefs(NT);
        check({name, "_busy_end"}, 64'(load_busy), 64'(0));
        check({name, "_s_ready_end"}, 64'(s_ready), 64'(1));
        check({name, "_c_ready_end"}, 64'(c_ready), 64'(0));
        step();
        check({name, "_coef_count"}, 64'(coef_cnt - base), 64'(NT));
        check({name, "_coef_left"}, 64'(cq.size()), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int errs;
        int first_err;
        logic [5:0] pat;

        rst = 1'b1; s_valid = 1'b0; s_i = '0; s_q = '0; stop_in = 1'b0;
        c_start = 1'b0; c_valid = 1'b0; c_i = '0; c_q = '0;

        // Test 1 rows 0..4: three back-to-back samples, stop_in low.
        tbl.push_back('{1'b1,  24'sd1, -24'sd1, 1'b0, 1'b0});
        tbl.push_back('{1'b1,  24'sd2, -24'sd2, 1'b0, 1'b1});
        tbl.push_back('{1'b1,  24'sd3, -24'sd3, 1'b0, 1'b1});
        tbl.push_back('{1'b0,  24'sd0,  24'sd0, 1'b0, 1'b1});
        tbl.push_back('{1'b0,  24'sd0,  24'sd0, 1'b0, 1'b0});
        // Test 3 rows 5..18: fill under stop, then toggle stop every cycle.
        tbl.push_back('{1'b1, 24'sd20, -24'sd20, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 24'sd21, -24'sd21, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 24'sd22, -24'sd22, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 24'sd23, -24'sd23, 1'b1, 1'b0});
        tbl.push_back('{1'b0,  24'sd0,  24'sd0, 1'b1, 1'b0});
        for (int k = 0; k < 9; k++)
            tbl.push_back('{1'b0, 24'sd0, 24'sd0, 1'(k % 2), 1'((k % 2 == 0) && (k < 8))});

        #12;
        check("rst_push_in", 64'(push_in), 64'(0));
        check("rst_push_coef", 64'(push_coef), 64'(0));
        check("rst_load_busy", 64'(load_busy), 64'(0));
        check("rst_load_err", 64'(load_err), 64'(0));
        check("rst_s_ready", 64'(s_ready), 64'(1));
        check("rst_c_ready", 64'(c_ready), 64'(0));
        check("rst_coef_addr", 64'(coef_addr), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_rows(0, 4, "t1_push");
        check("t1_drained", 64'(sq.size()), 64'(0));

        // Test 2: six offered under stop, four accepted, then four pushes.
        stop_in = 1'b1;
        base    = acc_cnt;
        for (int k = 0; k < 8; k++) begin
            s_valid = (acc_cnt - base) < 6;
            s_i     = DW'(30 + acc_cnt - base);
            s_q     = -DW'(30 + acc_cnt - base);
            step();
        end
        s_valid = 1'b0;
        check("t2_accepted", 64'(acc_cnt - base), 64'(4));
        check("t2_s_ready_full", 64'(s_ready), 64'(0));
        check("t2_push_held", 64'(push_in), 64'(0));
        stop_in = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            pat[5-k] = push_in;
        end
        check("t2_push_pattern", 64'(pat), 64'(6'b111100));
        check("t2_s_ready_back", 64'(s_ready), 64'(1));

        run_rows(5, tbl.size() - 1, "t3_push");
        check("t3_drained", 64'(sq.size()), 64'(0));

        // Test 4: coefficient load with two samples still queued.
        stop_in = 1'b1;
        s_valid = 1'b1; s_i = 24'sd100; s_q = -24'sd100;
        step();
        s_i = 24'sd101; s_q = -24'sd101;
        step();
        s_valid = 1'b0;
        start_load();
        check("t4_busy", 64'(load_busy), 64'(1));
        check("t4_s_ready_drain", 64'(s_ready), 64'(0));
        base    = push_cnt;
        stop_in = 1'b0;
        wait_c_ready();
        check("t4_drained_pushes", 64'(push_cnt - base), 64'(2));
        check("t4_busy_load", 64'(load_busy), 64'(1));
        full_load("t4");

        // Test 5: reset in the middle of a load.
        start_load();
        wait_c_ready();
        load_coefs(10);
        rst = 1'b1;
        #1;
        check("t5_push_coef", 64'(push_coef), 64'(0));
        check("t5_coef_addr", 64'(coef_addr), 64'(0));
        check("t5_coef_i", 64'(coef_i), 64'(0));
        check("t5_samp_i", 64'(samp_i), 64'(0));
        check("t5_samp_q", 64'(samp_q), 64'(0));
        check("t5_load_busy", 64'(load_busy), 64'(0));
        check("t5_c_ready", 64'(c_ready), 64'(0));
        step();
        step();
        rst = 1'b0;
        step();
        check("t5_run_s_ready", 64'(s_ready), 64'(1));
        start_load();
        wait_c_ready();
        full_load("t5");

        // Test 6: stall c_valid in LOAD.
        start_load();
        wait_c_ready();
        errs      = 0;
        first_err = -1;
        for (int k = 1; k <= 300; k++) begin
            step();
            if (load_err) begin
                errs++;
                if (first_err < 0) first_err = k;
            end
        end
`ifdef FIR_PUSH_TX_LOAD_TIMEOUT_EN
        check("t6_err_pulses", 64'(errs), 64'(1));
        check("t6_err_cycle", 64'(first_err), 64'(255));
        check("t6_busy_after", 64'(load_busy), 64'(0));
        start_load();
        wait_c_ready();
`else
        check("t6_err_pulses", 64'(errs), 64'(0));
        check("t6_busy_stalled", 64'(load_busy), 64'(1));
`endif
        full_load("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
